// File: rtl/div_recombiner.sv
// rtl/div_recombiner.sv - sequential Q*D+R reconstruction with dividend match check
module div_recombiner #(
    parameter int NX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NX-2:0]     D,
    input  logic [NX-1:0]     Q,
    input  logic [2*NX-2:0]   R,
    input  logic [2*NX-3:0]   X,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*NX-1:0]   P,
    output logic              match,
    output logic              busy
);

    // Counter is one bit wider than strictly needed so it can step past NX-1.
    localparam int CW = $clog2(NX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*NX-1:0]    d_sh;
    logic [NX-1:0]      q_sh;
    logic [2*NX-3:0]    x_reg;
    logic [2*NX-1:0]    acc;
    logic [2*NX-1:0]    acc_step;
    logic [CW-1:0]      cnt;
    logic               match_r;
    logic               last_step;

    // One shift-add step: add the shifted divisor when the current quotient LSB is set.
    assign acc_step  = q_sh[0] ? (acc + d_sh) : acc;
    assign last_step = (cnt == CW'(NX - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DONE);
    assign P         = acc;
    assign match     = match_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, NX multiply steps, hold result until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = MUL;
            MUL:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add accumulation and registered match flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sh    <= '0;
            q_sh    <= '0;
            x_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            match_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_sh    <= {{(NX + 1){1'b0}}, D};
                        q_sh    <= Q;
                        x_reg   <= X;
                        acc     <= {1'b0, R};
                        cnt     <= '0;
                        match_r <= 1'b0;
                    end
                end
                MUL: begin
                    acc  <= acc_step;
                    d_sh <= d_sh << 1;
                    q_sh <= q_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_step) begin
                        match_r <= (acc_step == {2'b00, x_reg});
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        match_r <= 1'b0;
                    end
                end
                default: begin
                    match_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_recombiner.sv
// tb/tb_div_recombiner.sv - self-checking bench for div_recombiner
module tb_div_recombiner;

    localparam int NX = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NX-2:0]     d;
    logic [NX-1:0]     q;
    logic [2*NX-2:0]   r;
    logic [2*NX-3:0]   x;
    logic              out_valid;
    logic              out_ready;
    logic [2*NX-1:0]   p;
    logic              match;
    logic              busy;

    int errors = 0;
    int checks = 0;

    div_recombiner #(.NX(NX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (d),
        .Q         (q),
        .R         (r),
        .X         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p),
        .match     (match),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_match"},     32'(match),     32'd0);
    endtask

    // Reference: the reconstructed dividend is simply Q*D+R in unsigned arithmetic.
    task automatic run_txn(input string tag, input int unsigned dv, input int unsigned qv,
                           input int unsigned rv, input int unsigned xv, input int hold);
        int unsigned exp_p;
        int          lat;
        logic [2*NX-1:0] held_p;
        logic        stable;
        exp_p = qv * dv + rv;
        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        d = (NX-1)'(dv); q = NX'(qv); r = (2*NX-1)'(rv); x = (2*NX-2)'(xv);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_ready_in_mul"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy_in_mul"},  32'(busy),     32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(NX));
        chk({tag, "_P"}, 32'(p), exp_p);
        chk({tag, "_match"}, 32'(match), 32'(exp_p == xv));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        if (hold > 0) begin
            held_p = p;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i % 3 == 0);
                d = 7'd1; q = 8'd1; r = 15'd1; x = 14'd2;
                @(negedge clk);
                if (!out_valid || p !== held_p || in_ready) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
            chk({tag, "_hold_P"}, 32'(p), exp_p);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle_outputs({tag, "_after"});
    endtask

    initial begin
        logic        saw_valid;
        int unsigned rd, rq, rr, rx, re;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        d = '0; q = '0; r = '0; x = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_P", 32'(p), 32'd0);
        rst_n = 1'b1;

        run_txn("basic",    5,   12,  3,     63,  0);
        run_txn("mismatch", 5,   12,  3,     64,  0);
        run_txn("maximum",  127, 255, 32767, 0,   0);
        run_txn("backpr",   9,   200, 17,    1817, 20);
        run_txn("q_zero",   77,  0,   100,   100, 0);
        run_txn("d_zero",   0,   99,  555,   555, 0);

        // Reset in the middle of a multiply abandons it.
        @(negedge clk);
        d = 7'd100; q = 8'd200; r = 15'd5; x = 14'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        chk("midreset_P", 32'(p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midreset_no_valid", 32'(saw_valid), 32'd0);
        run_txn("post_reset", 3, 2, 1, 7, 0);

        // Randomized transactions against the arithmetic reference.
        for (int i = 0; i < 16; i++) begin
            rd = $urandom_range(127, 0);
            rq = $urandom_range(255, 0);
            rr = $urandom_range(32767, 0);
            re = rq * rd + rr;
            rx = ((i % 2 == 0) && re < 16384) ? re : $urandom_range(16383, 0);
            run_txn("random", rd, rq, rr, rx, (i % 4 == 1) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
